axi_boot_rom_slave: RTL and testbench
=====================================

// Module: axi_boot_rom_slave
// PURPOSE
//  AXI4 responder fronting the MCU boot ROM. It answers core/debug reads at ROM_START_ADDR out of a
//  synchronous single-port ROM (1-cycle read latency) and rejects all writes with an error response.
//  It sits on a slave port of the AXI interconnect, beside the instruction and data RAM slaves.
// PARAMETERS
//  AXI_ADDR_WIDTH  32        address width
//  AXI_DATA_WIDTH  32        data width; one beat = one 32-bit word
//  AXI_ID_WIDTH    4         ID width (slave side of interconnect)
//  ROM_ADDR_WIDTH  12        ROM word-address bits; window = 4*2^ROM_ADDR_WIDTH bytes
//  ROM_START_ADDR  32'h8000  byte base address of the ROM window
// PORTS
//  clk        in   1    clock
//  rst        in   1    synchronous reset, active-high
//  ar_id/ar_addr/ar_len/ar_burst  in  ID/ADDR/8/2   read address channel; ar_valid in 1; ar_ready out 1
//  r_id/r_data/r_resp/r_last      out ID/DATA/2/1   read data channel; r_valid out 1; r_ready in 1
//  aw_id/aw_addr                  in  ID/ADDR       write address channel; aw_valid in 1; aw_ready out 1
//  w_data/w_last                  in  DATA/1        write data channel (data discarded); w_valid in 1; w_ready out 1
//  b_id/b_resp                    out ID/2          write response channel; b_valid out 1; b_ready in 1
//  rom_req    out  1               ROM read strobe
//  rom_addr   out  ROM_ADDR_WIDTH  ROM word address, registered, held between fetches
//  rom_rdata  in   DATA            ROM data, valid the cycle after rom_req, stable while rom_addr is held
// BEHAVIOUR
//  Reset: read and write FSMs go IDLE.
//   - r_valid, r_last, b_valid, w_ready and rom_req are 0.
//   - r_id, r_resp, b_id, b_resp and rom_addr are 0.
//   - ar_ready and aw_ready are 0 in the reset cycle and 1 in the first IDLE cycle.
//   - Reset mid-burst abandons the transfer; no further beats or responses are issued.
//  Read FSM: R_IDLE -> R_FETCH -> R_DATA -> (R_FETCH | R_IDLE).
//   - ar_ready = (state == R_IDLE).
//   - On the AR handshake, latch id, addr and beats = ar_len+1.
//   - R_FETCH lasts one cycle. If the current address is in range, rom_req=1 with
//     rom_addr = (addr-ROM_START_ADDR)>>2, truncated to ROM_ADDR_WIDTH. Then go to R_DATA.
//   - R_DATA: r_valid=1, r_id = latched id, r_last = (remaining beats == 1).
//     In range: r_data = rom_rdata, r_resp = 2'b00. Otherwise: r_data = 0, r_resp = 2'b11 (DECERR).
//     All R outputs are held stable until r_ready.
//   - On the R handshake: if not last, update addr and go to R_FETCH; if last, go to R_IDLE.
//     Address update: ar_burst FIXED (00) holds addr; INCR (01) and WRAP (10, treated as INCR) do addr+4.
//   - Latency: AR handshake at cycle T -> rom_req at T+1 -> r_valid at T+2.
//     Throughput is one beat per 2 cycles.
//   - In range means ROM_START_ADDR <= addr < ROM_START_ADDR + 4*2^ROM_ADDR_WIDTH.
//     The check is made per beat, so an INCR burst running past the top returns DECERR for the
//     overflowing beats only. addr[1:0] are ignored.
//  Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE. It runs independently of the read FSM.
//   - aw_ready = (state == W_IDLE). On the AW handshake, latch aw_id and range flag.
//   - W_DATA: w_ready=1; every beat is consumed and discarded until the w_valid&w_last handshake.
//   - W_RESP: b_valid=1, b_id = latched id, b_resp = 2'b10 (SLVERR) if in range else 2'b11 (DECERR).
//     Held until b_ready; then go to W_IDLE.
//  Simultaneous events:
//   - AR and AW in the same cycle are both accepted.
//   - rom_req is driven only by the read FSM, so there is no ROM contention.
// TESTING
//  - Single read: AR addr=0x8004, len=0, id=3, r_ready=1; rom_rdata=0xDEADBEEF at T+2
//    -> r_valid at T+2, r_data=0xDEADBEEF, r_resp=0, r_last=1, r_id=3; rom_addr=1 at T+1.
//  - INCR burst: addr=0x8000, len=3, r_ready toggling 1/0 -> 4 beats with rom_addr 0,1,2,3,
//    r_last only on beat 4, and data stable across stalls.
//  - Window edge: addr=0xBFFC (4 KiWord window), len=1, INCR -> beat1 OKAY rom_addr=0xFFF,
//    beat2 r_resp=2'b11, r_data=0, no rom_req.
//  - Out-of-range read addr=0x0 -> single beat r_resp=2'b11, rom_req never asserted.
//  - Write burst: AW addr=0x8000 id=5, 3 W beats with w_last on beat 3, b_ready held 0 for 4 cycles
//    -> b_valid held, b_resp=2'b10, b_id=5; aw_ready=0 until the B handshake.
//  - Reset asserted in R_DATA mid-burst together with simultaneous AR/AW -> next cycle r_valid=0,
//    b_valid=0; both ready outputs return to 1 after reset deasserts.

Source files
------------

// File: rtl/axi_boot_rom_slave.sv
// AXI4 read-only responder for the MCU boot ROM: serves reads one beat per two cycles
// from a 1-cycle-latency synchronous ROM and answers every write with an error.
module axi_boot_rom_slave #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int ROM_ADDR_WIDTH = 12,
   parameter logic [AXI_ADDR_WIDTH-1:0] ROM_START_ADDR = 'h8000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [AXI_ID_WIDTH-1:0]   ar_id,
   input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
   input  logic [7:0]                ar_len,
   input  logic [1:0]                ar_burst,
   input  logic                      ar_valid,
   output logic                      ar_ready,
   output logic [AXI_ID_WIDTH-1:0]   r_id,
   output logic [AXI_DATA_WIDTH-1:0] r_data,
   output logic [1:0]                r_resp,
   output logic                      r_last,
   output logic                      r_valid,
   input  logic                      r_ready,
   input  logic [AXI_ID_WIDTH-1:0]   aw_id,
   input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
   input  logic                      aw_valid,
   output logic                      aw_ready,
   input  logic [AXI_DATA_WIDTH-1:0] w_data,
   input  logic                      w_last,
   input  logic                      w_valid,
   output logic                      w_ready,
   output logic [AXI_ID_WIDTH-1:0]   b_id,
   output logic [1:0]                b_resp,
   output logic                      b_valid,
   input  logic                      b_ready,
   output logic                      rom_req,
   output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
   input  logic [AXI_DATA_WIDTH-1:0] rom_rdata
);

   // state   | meaning
   // R_IDLE  | waiting for AR
   // R_FETCH | ROM strobe for the current beat (skipped strobe if out of window)
   // R_DATA  | beat presented on R, held until r_ready
   // W_IDLE  | waiting for AW
   // W_DATA  | sinking W beats until w_last
   // W_RESP  | error response presented on B, held until b_ready
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [AXI_ADDR_WIDTH:0] WIN_LO = {1'b0, ROM_START_ADDR};
   localparam logic [AXI_ADDR_WIDTH:0] WIN_HI =
      WIN_LO + ((AXI_ADDR_WIDTH+1)'(1) << (ROM_ADDR_WIDTH + 2));

   function automatic logic in_window(input logic [AXI_ADDR_WIDTH-1:0] a);
      logic [AXI_ADDR_WIDTH:0] aw;
      aw = {1'b0, a[AXI_ADDR_WIDTH-1:2], 2'b00};
      return (aw >= WIN_LO) && (aw < WIN_HI);
   endfunction

   r_state_t r_state, r_state_nxt;
   w_state_t w_state, w_state_nxt;

   logic [AXI_ID_WIDTH-1:0]   rid_q, bid_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, next_addr, next_off;
   logic [8:0]                beats_q;
   logic                      fixed_q, range_q, w_range_q;
   logic [ROM_ADDR_WIDTH-1:0] rom_addr_q;
   logic                      load_addr, last_beat;

   assign next_off = next_addr - ROM_START_ADDR;
   assign r_id     = rid_q;
   assign b_id     = bid_q;
   assign rom_addr = rom_addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
      end else begin
         r_state <= r_state_nxt;
         w_state <= w_state_nxt;
      end
   end

   always_comb begin
      r_state_nxt = r_state;
      ar_ready    = 1'b0;
      r_valid     = 1'b0;
      r_last      = 1'b0;
      r_resp      = RESP_OKAY;
      r_data      = '0;
      rom_req     = 1'b0;
      load_addr   = 1'b0;
      next_addr   = addr_q;
      last_beat   = (beats_q == 9'd1);
      case (r_state)
         R_IDLE: begin
            ar_ready  = ~rst;
            next_addr = ar_addr;
            if (ar_valid && !rst) begin
               load_addr   = 1'b1;
               r_state_nxt = R_FETCH;
            end
         end
         R_FETCH: begin
            rom_req     = range_q;
            r_state_nxt = R_DATA;
         end
         R_DATA: begin
            r_valid   = 1'b1;
            r_last    = last_beat;
            r_resp    = range_q ? RESP_OKAY : RESP_DECERR;
            r_data    = range_q ? rom_rdata : '0;
            // WRAP is deliberately handled as INCR
            next_addr = fixed_q ? addr_q : addr_q + AXI_ADDR_WIDTH'(4);
            if (r_ready) begin
               if (last_beat) begin
                  r_state_nxt = R_IDLE;
               end else begin
                  load_addr   = 1'b1;
                  r_state_nxt = R_FETCH;
               end
            end
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rid_q      <= '0;
         addr_q     <= '0;
         beats_q    <= '0;
         fixed_q    <= 1'b0;
         range_q    <= 1'b0;
         rom_addr_q <= '0;
      end else begin
         if (ar_ready && ar_valid) begin
            rid_q   <= ar_id;
            beats_q <= {1'b0, ar_len} + 9'd1;
            fixed_q <= (ar_burst == 2'b00);
         end else if (r_valid && r_ready && !last_beat) begin
            beats_q <= beats_q - 9'd1;
         end
         // ROM address only moves for in-window beats so rom_rdata stays valid
         if (load_addr) begin
            addr_q  <= next_addr;
            range_q <= in_window(next_addr);
            if (in_window(next_addr))
               rom_addr_q <= next_off[ROM_ADDR_WIDTH+1:2];
         end
      end
   end

   always_comb begin
      w_state_nxt = w_state;
      aw_ready    = 1'b0;
      w_ready     = 1'b0;
      b_valid     = 1'b0;
      b_resp      = RESP_OKAY;
      case (w_state)
         W_IDLE: begin
            aw_ready = ~rst;
            if (aw_valid && !rst) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            w_ready = 1'b1;
            if (w_valid && w_last) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            b_valid = 1'b1;
            b_resp  = w_range_q ? RESP_SLVERR : RESP_DECERR;
            if (b_ready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bid_q     <= '0;
         w_range_q <= 1'b0;
      end else if (aw_ready && aw_valid) begin
         bid_q     <= aw_id;
         w_range_q <= in_window(aw_addr);
      end
   end

   logic unused_bits;
   assign unused_bits = ^{w_data, next_off};

endmodule

// File: tb/tb_axi_boot_rom_slave.sv
// Bench for axi_boot_rom_slave: directed AXI traffic, a transaction-level model of the
// expected R/B beats and ROM fetches, and a per-cycle compare against the DUT.
module tb_axi_boot_rom_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  ar_id = '0;
   logic [31:0] ar_addr = '0;
   logic [7:0]  ar_len = '0;
   logic [1:0]  ar_burst = '0;
   logic        ar_valid = 1'b0;
   logic        ar_ready;
   logic [3:0]  r_id;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last, r_valid;
   logic        r_ready = 1'b0;
   logic [3:0]  aw_id = '0;
   logic [31:0] aw_addr = '0;
   logic        aw_valid = 1'b0;
   logic        aw_ready;
   logic [31:0] w_data = '0;
   logic        w_last = 1'b0, w_valid = 1'b0;
   logic        w_ready;
   logic [3:0]  b_id;
   logic [1:0]  b_resp;
   logic        b_valid;
   logic        b_ready = 1'b0;
   logic        rom_req;
   logic [11:0] rom_addr;
   logic [31:0] rom_rdata = '0;

   axi_boot_rom_slave dut (
      .clk(clk), .rst(rst),
      .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_burst(ar_burst),
      .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
      .r_valid(r_valid), .r_ready(r_ready),
      .aw_id(aw_id), .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
      .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .rom_req(rom_req), .rom_addr(rom_addr), .rom_rdata(rom_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [11:0] idx);
      return (idx == 12'd1) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(idx) * 32'h11;
   endfunction

   always @(posedge clk) if (rom_req) rom_rdata <= rom_word(rom_addr);

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rbeat_t;
   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
   } bexp_t;

   rbeat_t      exp_r[$];
   bexp_t       exp_b[$];
   logic [11:0] exp_f[$];

   int n_checks = 0;
   int n_fail   = 0;
   int rom_req_cnt = 0;
   logic [11:0] last_rom_addr = '0;
   int rr_mode = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event missing or unexpected at %0t", name, $time);
   endtask

   // Expected beats come straight from the burst rules: address per beat, window test, ROM word.
   task automatic model_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [3:0] id);
      for (int i = 0; i <= len; i++) begin
         logic [31:0] a;
         logic        inr;
         rbeat_t      b;
         a   = (burst == 2'b00) ? addr : addr + 32'(4 * i);
         inr = (a >= 32'h8000) && (a < 32'hC000);
         b.data = inr ? rom_word(12'((a - 32'h8000) >> 2)) : 32'h0;
         b.resp = inr ? 2'b00 : 2'b11;
         b.last = (i == len);
         b.id   = id;
         exp_r.push_back(b);
         if (inr) exp_f.push_back(12'((a - 32'h8000) >> 2));
      end
   endtask

   task automatic monitor();
      if (rst) return;
      if (rom_req) begin
         rom_req_cnt++;
         last_rom_addr = rom_addr;
         if (exp_f.size() == 0) fail_now("rom_req_unexpected");
         else chk("rom_addr", 64'(rom_addr), 64'(exp_f.pop_front()));
      end
      if (r_valid) begin
         if (exp_r.size() == 0) fail_now("r_valid_unexpected");
         else begin
            chk("r_data", 64'(r_data), 64'(exp_r[0].data));
            chk("r_resp", 64'(r_resp), 64'(exp_r[0].resp));
            chk("r_last", 64'(r_last), 64'(exp_r[0].last));
            chk("r_id",   64'(r_id),   64'(exp_r[0].id));
            if (r_ready) void'(exp_r.pop_front());
         end
      end
      if (b_valid) begin
         if (exp_b.size() == 0) fail_now("b_valid_unexpected");
         else begin
            chk("b_id",   64'(b_id),   64'(exp_b[0].id));
            chk("b_resp", 64'(b_resp), 64'(exp_b[0].resp));
            if (b_ready) void'(exp_b.pop_front());
         end
      end
   endtask

   task automatic send_ar(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [3:0] id);
      bit ok = 0;
      model_read(addr, len, burst, id);
      ar_addr = addr; ar_len = 8'(len); ar_burst = burst; ar_id = id; ar_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = ar_ready;
      end
      if (!ok) fail_now("ar_ready_timeout");
      @(posedge clk); #1;
      ar_valid = 1'b0;
   endtask

   task automatic send_aw(input logic [31:0] addr, input logic [3:0] id);
      bit ok = 0;
      bexp_t e;
      e.id   = id;
      e.resp = ((addr >= 32'h8000) && (addr < 32'hC000)) ? 2'b10 : 2'b11;
      exp_b.push_back(e);
      aw_addr = addr; aw_id = id; aw_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = aw_ready;
      end
      if (!ok) fail_now("aw_ready_timeout");
      @(posedge clk); #1;
      aw_valid = 1'b0;
   endtask

   task automatic send_w(input int n);
      for (int i = 0; i < n; i++) begin
         bit ok = 0;
         w_valid = 1'b1; w_last = (i == n - 1); w_data = 32'h5A5A0000 + 32'(i);
         for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = w_ready;
         end
         if (!ok) fail_now("w_ready_timeout");
         @(posedge clk); #1;
      end
      w_valid = 1'b0; w_last = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (exp_r.size() != 0 || exp_b.size() != 0); i++)
         @(negedge clk);
      if (exp_r.size() != 0 || exp_b.size() != 0) begin
         fail_now("drain_timeout");
         exp_r.delete(); exp_b.delete();
      end
      exp_f.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      int cnt0;
      fork
         forever begin @(negedge clk); monitor(); end
         forever begin
            @(posedge clk); #1;
            if (rr_mode == 1) r_ready = ~r_ready;
            else r_ready = (rr_mode == 0);
         end
      join_none

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ar_ready", 64'(ar_ready), 64'(0));
      chk("rst_aw_ready", 64'(aw_ready), 64'(0));
      chk("rst_r_valid",  64'(r_valid),  64'(0));
      chk("rst_b_valid",  64'(b_valid),  64'(0));
      chk("rst_w_ready",  64'(w_ready),  64'(0));
      chk("rst_rom_req",  64'(rom_req),  64'(0));
      chk("rst_rom_addr", 64'(rom_addr), 64'(0));
      chk("rst_r_id",     64'(r_id),     64'(0));
      chk("rst_b_resp",   64'(b_resp),   64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ar_ready", 64'(ar_ready), 64'(1));
      chk("idle_aw_ready", 64'(aw_ready), 64'(1));
      @(posedge clk); #1;

      // single read with literal latency/data expectations
      model_read(32'h8004, 0, 2'b01, 4'd3);
      ar_addr = 32'h8004; ar_len = 8'd0; ar_burst = 2'b01; ar_id = 4'd3; ar_valid = 1'b1;
      @(posedge clk); #1;
      ar_valid = 1'b0;
      @(negedge clk);
      chk("single_rom_req_t1",  64'(rom_req),  64'(1));
      chk("single_rom_addr_t1", 64'(rom_addr), 64'(1));
      chk("single_r_valid_t1",  64'(r_valid),  64'(0));
      @(negedge clk);
      chk("single_r_valid_t2", 64'(r_valid), 64'(1));
      chk("single_r_data_t2",  64'(r_data),  64'(32'hDEADBEEF));
      chk("single_r_last_t2",  64'(r_last),  64'(1));
      chk("single_r_id_t2",    64'(r_id),    64'(3));
      drain();

      // INCR burst with toggling r_ready
      rr_mode = 1;
      cnt0 = rom_req_cnt;
      send_ar(32'h8000, 3, 2'b01, 4'd6);
      drain();
      chk("incr_fetches", 64'(rom_req_cnt - cnt0), 64'(4));
      chk("incr_last_rom_addr", 64'(last_rom_addr), 64'(3));
      rr_mode = 0;

      // window top edge: second beat overflows
      cnt0 = rom_req_cnt;
      send_ar(32'h0000BFFC, 1, 2'b01, 4'd2);
      drain();
      chk("edge_fetches", 64'(rom_req_cnt - cnt0), 64'(1));
      chk("edge_rom_addr", 64'(last_rom_addr), 64'(12'hFFF));

      // out of range read
      cnt0 = rom_req_cnt;
      send_ar(32'h0, 0, 2'b01, 4'd9);
      drain();
      chk("oor_no_fetch", 64'(rom_req_cnt - cnt0), 64'(0));

      // FIXED and WRAP bursts
      rr_mode = 1;
      send_ar(32'h8010, 2, 2'b00, 4'd1);
      drain();
      send_ar(32'h8020, 1, 2'b10, 4'd15);
      drain();
      rr_mode = 0;

      // write burst, B back-pressured for 4 cycles
      send_aw(32'h8000, 4'd5);
      @(negedge clk);
      chk("aw_busy_after_hs", 64'(aw_ready), 64'(0));
      @(posedge clk); #1;
      send_w(3);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("b_hold_valid", 64'(b_valid), 64'(1));
         chk("b_hold_aw_ready", 64'(aw_ready), 64'(0));
         @(posedge clk); #1;
      end
      b_ready = 1'b1;
      @(posedge clk); #1;
      b_ready = 1'b0;
      @(negedge clk);
      chk("b_done_valid", 64'(b_valid), 64'(0));
      chk("b_done_aw_ready", 64'(aw_ready), 64'(1));
      drain();

      // out-of-range write, concurrent with a read
      b_ready = 1'b1;
      model_read(32'h8008, 1, 2'b01, 4'd4);
      begin
         bexp_t e;
         e.id = 4'd9; e.resp = 2'b11;
         exp_b.push_back(e);
      end
      ar_addr = 32'h8008; ar_len = 8'd1; ar_burst = 2'b01; ar_id = 4'd4; ar_valid = 1'b1;
      aw_addr = 32'h0; aw_id = 4'd9; aw_valid = 1'b1;
      @(negedge clk);
      chk("both_ar_ready", 64'(ar_ready), 64'(1));
      chk("both_aw_ready", 64'(aw_ready), 64'(1));
      @(posedge clk); #1;
      ar_valid = 1'b0; aw_valid = 1'b0;
      send_w(2);
      drain();
      b_ready = 1'b0;

      // reset mid-burst with pending B and simultaneous AR/AW
      rr_mode = 2;
      @(posedge clk); #1;
      send_ar(32'h8000, 3, 2'b01, 4'd8);
      send_aw(32'h8100, 4'd7);
      send_w(1);
      begin
         bit ok = 0;
         for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = r_valid && b_valid;
         end
         if (!ok) fail_now("pre_reset_busy_timeout");
      end
      @(posedge clk); #1;
      rst = 1'b1; ar_valid = 1'b1; aw_valid = 1'b1;
      exp_r.delete(); exp_b.delete(); exp_f.delete();
      @(negedge clk);
      chk("rcyc_ar_ready", 64'(ar_ready), 64'(0));
      chk("rcyc_aw_ready", 64'(aw_ready), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0; ar_valid = 1'b0; aw_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_r_valid",  64'(r_valid),  64'(0));
      chk("post_rst_b_valid",  64'(b_valid),  64'(0));
      chk("post_rst_ar_ready", 64'(ar_ready), 64'(1));
      chk("post_rst_aw_ready", 64'(aw_ready), 64'(1));
      chk("post_rst_rom_addr", 64'(rom_addr), 64'(0));
      rr_mode = 0;
      repeat (6) @(posedge clk);
      #1;

      // ROM still usable after the abandoned burst
      send_ar(32'h8040, 1, 2'b01, 4'd12);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish at %0t", $time);
      $fatal(1);
   end

endmodule
